// File: rtl/int_ctrl_n.sv
// Interrupt controller: NUM_INT synchronised sources with per-channel trigger, polarity,
// mask and W1C pending, merged into one registered active-low system interrupt.
module int_ctrl_n #(
    parameter int                       MM_ADDR_WIDTH     = 8,
    parameter int                       MM_DATA_WIDTH     = 16,
    parameter int                       NUM_INT           = 4,
    parameter logic [NUM_INT-1:0]       TRIG_RST          = {NUM_INT{1'b1}},
    parameter logic [NUM_INT-1:0]       POL_RST           = {NUM_INT{1'b1}},
    parameter logic [MM_ADDR_WIDTH-1:0] REG_ADDR_INT_PND  = 'h04,
    parameter logic [MM_ADDR_WIDTH-1:0] REG_ADDR_INT_CLR  = 'h06,
    parameter logic [MM_ADDR_WIDTH-1:0] REG_ADDR_INT_MSK  = 'h08,
    parameter logic [MM_ADDR_WIDTH-1:0] REG_ADDR_INT_TRIG = 'h0A,
    parameter logic [MM_ADDR_WIDTH-1:0] REG_ADDR_INT_POL  = 'h0C,
    parameter logic [MM_ADDR_WIDTH-1:0] REG_ADDR_INT_CTRL = 'h0E,
    parameter logic [MM_ADDR_WIDTH-1:0] REG_ADDR_INT_VEC  = 'h10,
    parameter logic [MM_ADDR_WIDTH-1:0] REG_ADDR_INT_RAW  = 'h12
) (
    input  logic                     clk_sys_i,
    input  logic                     rst_n_i,
    input  logic [MM_ADDR_WIDTH-1:0] mm_s_addr_i,
    input  logic [MM_DATA_WIDTH-1:0] mm_s_wdata_i,
    output logic [MM_DATA_WIDTH-1:0] mm_s_rdata_o,
    input  logic                     mm_s_we_i,
    input  logic [NUM_INT-1:0]       int_i,
    output logic                     sys_int_o
);

    logic [NUM_INT-1:0] s0_q, s1_q, s2_q;
    logic [NUM_INT-1:0] pnd_q, pnd_d;
    logic [NUM_INT-1:0] msk_q, msk_d;
    logic [NUM_INT-1:0] trig_q, trig_d;
    logic [NUM_INT-1:0] pol_q, pol_d;
    logic               dis_q, dis_d;
    logic [1:0]         sup_q, sup_d;
    logic               sys_int_q, sys_int_d;

    logic [NUM_INT-1:0] a1, a2, evt, clr, act;
    logic [4:0]         vec_idx;
    logic               we_clr, we_msk, we_trig, we_pol, we_ctrl;

    assign we_clr  = mm_s_we_i && (mm_s_addr_i == REG_ADDR_INT_CLR);
    assign we_msk  = mm_s_we_i && (mm_s_addr_i == REG_ADDR_INT_MSK);
    assign we_trig = mm_s_we_i && (mm_s_addr_i == REG_ADDR_INT_TRIG);
    assign we_pol  = mm_s_we_i && (mm_s_addr_i == REG_ADDR_INT_POL);
    assign we_ctrl = mm_s_we_i && (mm_s_addr_i == REG_ADDR_INT_CTRL);

    always_comb begin
        a1      = s1_q ^ pol_q;
        a2      = s2_q ^ pol_q;
        // Edge detection is blanked while a POL/TRIG change settles through the compare.
        evt     = (trig_q & a1 & ~a2 & {NUM_INT{sup_q == 2'd0}}) | (~trig_q & a1);
        clr     = we_clr ? mm_s_wdata_i[NUM_INT-1:0] : '0;
        pnd_d   = (pnd_q & ~clr) | (evt & ~msk_q);
        msk_d   = we_msk  ? mm_s_wdata_i[NUM_INT-1:0] : msk_q;
        trig_d  = we_trig ? mm_s_wdata_i[NUM_INT-1:0] : trig_q;
        pol_d   = we_pol  ? mm_s_wdata_i[NUM_INT-1:0] : pol_q;
        dis_d   = we_ctrl ? mm_s_wdata_i[MM_DATA_WIDTH-1] : dis_q;
        sup_d   = sup_q;
        if (we_trig || we_pol) begin
            sup_d = 2'd2;
        end else if (sup_q != 2'd0) begin
            sup_d = sup_q - 2'd1;
        end
        act       = pnd_q & ~msk_q;
        sys_int_d = ~(|act) | dis_q;
    end

    always_ff @(posedge clk_sys_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            s0_q      <= POL_RST;
            s1_q      <= POL_RST;
            s2_q      <= POL_RST;
            pnd_q     <= '0;
            msk_q     <= '1;
            trig_q    <= TRIG_RST;
            pol_q     <= POL_RST;
            dis_q     <= 1'b1;
            sup_q     <= 2'd0;
            sys_int_q <= 1'b1;
        end else begin
            s0_q      <= int_i;
            s1_q      <= s0_q;
            s2_q      <= s1_q;
            pnd_q     <= pnd_d;
            msk_q     <= msk_d;
            trig_q    <= trig_d;
            pol_q     <= pol_d;
            dis_q     <= dis_d;
            sup_q     <= sup_d;
            sys_int_q <= sys_int_d;
        end
    end

    // Lowest-numbered active channel wins, so scan from the top down.
    always_comb begin
        vec_idx = '0;
        for (int i = NUM_INT - 1; i >= 0; i--) begin
            if (act[i]) vec_idx = 5'(i);
        end
    end

    always_comb begin
        mm_s_rdata_o = '0;
        if (rst_n_i) begin
            case (mm_s_addr_i)
                REG_ADDR_INT_PND:  mm_s_rdata_o[NUM_INT-1:0] = pnd_q;
                REG_ADDR_INT_MSK:  mm_s_rdata_o[NUM_INT-1:0] = msk_q;
                REG_ADDR_INT_TRIG: mm_s_rdata_o[NUM_INT-1:0] = trig_q;
                REG_ADDR_INT_POL:  mm_s_rdata_o[NUM_INT-1:0] = pol_q;
                REG_ADDR_INT_CTRL: mm_s_rdata_o[MM_DATA_WIDTH-1] = dis_q;
                REG_ADDR_INT_VEC: begin
                    mm_s_rdata_o[MM_DATA_WIDTH-1] = |act;
                    mm_s_rdata_o[4:0]             = vec_idx;
                end
                REG_ADDR_INT_RAW:  mm_s_rdata_o[NUM_INT-1:0] = s2_q ^ pol_q;
                default:           mm_s_rdata_o = '0;
            endcase
        end
    end

    assign sys_int_o = sys_int_q;

endmodule

// File: tb/tb_int_ctrl_n.sv
// Directed bench for int_ctrl_n (NUM_INT=4): reset values, edge/level triggering,
// W1C clear, masking, suppression after POL writes, global disable and mid-run reset.
module tb_int_ctrl_n;

    localparam int         AW = 8;
    localparam int         DW = 16;
    localparam int         N  = 4;
    localparam logic [7:0] A_PND  = 8'h04;
    localparam logic [7:0] A_CLR  = 8'h06;
    localparam logic [7:0] A_MSK  = 8'h08;
    localparam logic [7:0] A_TRIG = 8'h0A;
    localparam logic [7:0] A_POL  = 8'h0C;
    localparam logic [7:0] A_CTRL = 8'h0E;
    localparam logic [7:0] A_VEC  = 8'h10;
    localparam logic [7:0] A_RAW  = 8'h12;
    localparam logic [7:0] A_NONE = 8'h14;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [DW-1:0] rdata;
    logic          we;
    logic [N-1:0]  int_in;
    logic          sys_int;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    int_ctrl_n #(
        .MM_ADDR_WIDTH(AW),
        .MM_DATA_WIDTH(DW),
        .NUM_INT      (N)
    ) dut (
        .clk_sys_i   (clk),
        .rst_n_i     (rst_n),
        .mm_s_addr_i (addr),
        .mm_s_wdata_i(wdata),
        .mm_s_rdata_o(rdata),
        .mm_s_we_i   (we),
        .int_i       (int_in),
        .sys_int_o   (sys_int)
    );

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%04h expected 0x%04h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [7:0] a, input logic [15:0] d);
        @(negedge clk);
        addr  = a;
        wdata = d;
        we    = 1'b1;
        @(negedge clk);
        we    = 1'b0;
    endtask

    task automatic rd_chk(input string tag, input logic [7:0] a, input logic [15:0] exp);
        addr = a;
        #1;
        chk(tag, rdata, exp);
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        rst_n  = 1'b1;
        we     = 1'b0;
        addr   = '0;
        wdata  = '0;
        int_in = '1;
        #1 rst_n = 1'b0;
        #2;
        chk("rst_sys_low", {15'd0, sys_int}, 16'h0001);
        rd_chk("rst_rdata_low", A_MSK, 16'h0000);
        cyc(2);
        rst_n = 1'b1;

        // Reset values
        rd_chk("rst_pnd",  A_PND,  16'h0000);
        rd_chk("rst_msk",  A_MSK,  16'h000F);
        rd_chk("rst_trig", A_TRIG, 16'h000F);
        rd_chk("rst_pol",  A_POL,  16'h000F);
        rd_chk("rst_ctrl", A_CTRL, 16'h8000);
        rd_chk("rst_vec",  A_VEC,  16'h0000);
        rd_chk("rst_raw",  A_RAW,  16'h0000);
        rd_chk("rst_clr",  A_CLR,  16'h0000);
        chk("rst_sys", {15'd0, sys_int}, 16'h0001);

        // Falling edge on ch2: PND at edge 3, sys_int low at edge 4
        wr(A_MSK, 16'h0000);
        wr(A_CTRL, 16'h0000);
        int_in[2] = 1'b0;
        cyc(2);
        rd_chk("t1_pnd_e2", A_PND, 16'h0000);
        cyc(1);
        rd_chk("t1_pnd_e3", A_PND, 16'h0004);
        chk("t1_sys_e3", {15'd0, sys_int}, 16'h0001);
        cyc(1);
        chk("t1_sys_e4", {15'd0, sys_int}, 16'h0000);
        rd_chk("t1_vec", A_VEC, 16'h8002);
        int_in[2] = 1'b1;
        cyc(3);
        rd_chk("t1_rise_noevt", A_PND, 16'h0004);
        wr(A_CLR, 16'h0004);
        rd_chk("t1_pnd_clr", A_PND, 16'h0000);
        chk("t1_sys_clr_edge", {15'd0, sys_int}, 16'h0000);
        cyc(1);
        chk("t1_sys_after", {15'd0, sys_int}, 16'h0001);

        // ch1 and ch3 pending; priority vector and partial clear
        int_in = 4'b0101;
        cyc(4);
        rd_chk("t2_pnd", A_PND, 16'h000A);
        rd_chk("t2_vec", A_VEC, 16'h8001);
        int_in = 4'b1111;
        cyc(3);
        wr(A_CLR, 16'h0002);
        rd_chk("t2_vec_clr1", A_VEC, 16'h8003);
        cyc(1);
        chk("t2_sys_still_low", {15'd0, sys_int}, 16'h0000);
        wr(A_CLR, 16'h0008);
        chk("t2_sys_clr_edge", {15'd0, sys_int}, 16'h0000);
        cyc(1);
        chk("t2_sys_high", {15'd0, sys_int}, 16'h0001);

        // ch0 level, active-high
        wr(A_MSK, 16'h0001);
        int_in[0] = 1'b0;
        cyc(4);
        wr(A_TRIG, 16'h000E);
        wr(A_POL, 16'h000E);
        cyc(3);
        wr(A_CLR, 16'h000F);
        wr(A_MSK, 16'h0000);
        rd_chk("t3_pnd_idle", A_PND, 16'h0000);
        int_in[0] = 1'b1;
        cyc(4);
        rd_chk("t3_pnd_lvl", A_PND, 16'h0001);
        rd_chk("t3_raw_hi", A_RAW, 16'h0001);
        wr(A_CLR, 16'h0001);
        rd_chk("t3_pnd_reset", A_PND, 16'h0001);
        int_in[0] = 1'b0;
        cyc(4);
        rd_chk("t3_raw_lo", A_RAW, 16'h0000);
        wr(A_CLR, 16'h0001);
        rd_chk("t3_pnd_cleared", A_PND, 16'h0000);
        wr(A_MSK, 16'h0001);
        int_in[0] = 1'b1;
        cyc(4);
        wr(A_TRIG, 16'h000F);
        wr(A_POL, 16'h000F);
        cyc(3);
        wr(A_CLR, 16'h000F);
        wr(A_MSK, 16'h0000);
        rd_chk("t3_restore", A_PND, 16'h0000);

        // Masked edge is discarded; unmasking does not set retroactively
        wr(A_MSK, 16'h000F);
        int_in[0] = 1'b0;
        cyc(5);
        rd_chk("t4_pnd_masked", A_PND, 16'h0000);
        chk("t4_sys_masked", {15'd0, sys_int}, 16'h0001);
        wr(A_MSK, 16'h0000);
        cyc(3);
        rd_chk("t4_pnd_unmask", A_PND, 16'h0000);
        chk("t4_sys_unmask", {15'd0, sys_int}, 16'h0001);
        int_in[0] = 1'b1;
        cyc(3);

        // Event and CLR on the same bit in the same cycle: set wins
        int_in[1] = 1'b0;
        cyc(2);
        addr  = A_CLR;
        wdata = 16'h0002;
        we    = 1'b1;
        @(negedge clk);
        we    = 1'b0;
        rd_chk("t5_set_wins", A_PND, 16'h0002);
        int_in[1] = 1'b1;
        cyc(3);
        wr(A_CLR, 16'h0002);
        rd_chk("t5_pnd_clr", A_PND, 16'h0000);

        // POL writes with static inputs, and an edge landing in the suppress window
        wr(A_POL, 16'h0000);
        cyc(4);
        rd_chk("t5_pol_static0", A_PND, 16'h0000);
        wr(A_POL, 16'h000F);
        cyc(4);
        rd_chk("t5_pol_static1", A_PND, 16'h0000);
        int_in[3] = 1'b0;
        wr(A_POL, 16'h000F);
        cyc(4);
        rd_chk("t5_suppressed", A_PND, 16'h0000);
        int_in[3] = 1'b1;
        cyc(3);

        // RO/unmapped writes ignored, unmapped reads zero
        wr(A_PND, 16'h000F);
        rd_chk("ro_pnd_write", A_PND, 16'h0000);
        wr(A_NONE, 16'hFFFF);
        rd_chk("unmapped_rd", A_NONE, 16'h0000);
        wr(A_CTRL, 16'h7FFF);
        rd_chk("ctrl_unused_bits", A_CTRL, 16'h0000);

        // Masking a pending channel, then global disable
        int_in[0] = 1'b0;
        cyc(4);
        rd_chk("t6_pnd", A_PND, 16'h0001);
        chk("t6_sys_low", {15'd0, sys_int}, 16'h0000);
        wr(A_MSK, 16'h0001);
        cyc(1);
        chk("t6_sys_masked", {15'd0, sys_int}, 16'h0001);
        rd_chk("t6_pnd_kept", A_PND, 16'h0001);
        rd_chk("t6_vec_masked", A_VEC, 16'h0000);
        wr(A_MSK, 16'h0000);
        wr(A_CTRL, 16'h8000);
        cyc(2);
        chk("t6_sys_disabled", {15'd0, sys_int}, 16'h0001);
        rd_chk("t6_vec_disabled", A_VEC, 16'h8000);

        // Mid-run reset
        rst_n = 1'b0;
        #2;
        chk("t7_sys_in_rst", {15'd0, sys_int}, 16'h0001);
        rd_chk("t7_rdata_in_rst", A_PND, 16'h0000);
        int_in[0] = 1'b1;
        cyc(2);
        rst_n = 1'b1;
        cyc(3);
        rd_chk("t7_pnd",  A_PND,  16'h0000);
        rd_chk("t7_msk",  A_MSK,  16'h000F);
        rd_chk("t7_ctrl", A_CTRL, 16'h8000);
        rd_chk("t7_trig", A_TRIG, 16'h000F);
        rd_chk("t7_pol",  A_POL,  16'h000F);
        rd_chk("t7_vec",  A_VEC,  16'h0000);
        chk("t7_sys", {15'd0, sys_int}, 16'h0001);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
